// File: rtl/dcache_port_arbiter.sv
// Two-lane arbiter onto a single pipelined dcache port. Lane 0 has priority,
// a stalled grant is locked until accepted, and a FIFO routes responses back.
module dcache_port_arbiter #(
   parameter int OSTD_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        excep_flush_i,
   input  logic        l0_req_i,
   input  logic [3:0]  l0_we_i,
   input  logic [31:0] l0_addr_i,
   input  logic [31:0] l0_wdata_i,
   output logic        l0_addr_ok_o,
   output logic        l0_data_ok_o,
   output logic [31:0] l0_rdata_o,
   input  logic        l1_req_i,
   input  logic [3:0]  l1_we_i,
   input  logic [31:0] l1_addr_i,
   input  logic [31:0] l1_wdata_i,
   output logic        l1_addr_ok_o,
   output logic        l1_data_ok_o,
   output logic [31:0] l1_rdata_o,
   output logic        data_sram_req_o,
   output logic [3:0]  data_sram_we_o,
   output logic [31:0] data_sram_addr_o,
   output logic [31:0] data_sram_wdata_o,
   input  logic        data_sram_addr_ok_i,
   input  logic        data_sram_data_ok_i,
   input  logic [31:0] data_sram_rdata_i,
   output logic        busy_o,
   output logic        err_o
);
   localparam int PW = $clog2(OSTD_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

   state_e                state_q, state_d;
   logic [OSTD_DEPTH-1:0] own_q, own_d, dis_q, dis_d;
   logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  sel_vld, sel_own, full, req, push, pop;
   logic                  head_own, head_dis;

   // Owner: locked lane, or lane 0 first in IDLE
   always_comb begin
      sel_vld = 1'b0;
      sel_own = 1'b0;
      case (state_q)
         IDLE:  begin sel_vld = l0_req_i | l1_req_i; sel_own = ~l0_req_i; end
         LOCK0: begin sel_vld = 1'b1; sel_own = 1'b0; end
         LOCK1: begin sel_vld = 1'b1; sel_own = 1'b1; end
         default: begin sel_vld = 1'b0; sel_own = 1'b0; end
      endcase
   end

   assign full     = (cnt_q == CW'(OSTD_DEPTH));
   assign req      = rst_n & sel_vld & ~full & ~excep_flush_i;
   assign push     = req & data_sram_addr_ok_i;
   assign pop      = rst_n & data_sram_data_ok_i & (cnt_q != '0);
   assign head_own = own_q[rptr_q];
   assign head_dis = dis_q[rptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (excep_flush_i || push) state_d = IDLE;
      else if (req)              state_d = sel_own ? LOCK1 : LOCK0;
   end

   always_comb begin
      data_sram_req_o   = req;
      data_sram_we_o    = '0;
      data_sram_addr_o  = '0;
      data_sram_wdata_o = '0;
      if (req) begin
         data_sram_we_o    = sel_own ? l1_we_i    : l0_we_i;
         data_sram_addr_o  = sel_own ? l1_addr_i  : l0_addr_i;
         data_sram_wdata_o = sel_own ? l1_wdata_i : l0_wdata_i;
      end
      l0_addr_ok_o = push & ~sel_own;
      l1_addr_ok_o = push &  sel_own;
      l0_data_ok_o = pop & ~head_own & ~head_dis;
      l1_data_ok_o = pop &  head_own & ~head_dis;
      l0_rdata_o   = rst_n ? data_sram_rdata_i : '0;
      l1_rdata_o   = rst_n ? data_sram_rdata_i : '0;
      err_o        = rst_n & data_sram_data_ok_i & (cnt_q == '0);
      busy_o       = (cnt_q != '0) | (state_q != IDLE);
   end

   // Flush marks only live entries; a same-cycle pop already used the old bit
   always_comb begin
      own_d  = own_q;
      dis_d  = dis_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (excep_flush_i) begin
         for (int i = 0; i < OSTD_DEPTH; i++) begin
            if (CW'(PW'(PW'(i) - rptr_q)) < cnt_q) dis_d[i] = 1'b1;
         end
      end
      if (push) begin
         own_d[wptr_q] = sel_own;
         dis_d[wptr_q] = 1'b0;
         wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_q  <= '0;
         dis_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         own_q  <= own_d;
         dis_q  <= dis_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized bench for dcache_port_arbiter against a queue-based reference model.
module tb_dcache_port_arbiter;
   localparam int DEPTH = 2;

   logic        clk = 1'b0, rst_n;
   logic        excep_flush_i;
   logic        l0_req_i, l1_req_i;
   logic [3:0]  l0_we_i, l1_we_i;
   logic [31:0] l0_addr_i, l1_addr_i, l0_wdata_i, l1_wdata_i;
   logic        l0_addr_ok_o, l1_addr_ok_o, l0_data_ok_o, l1_data_ok_o;
   logic [31:0] l0_rdata_o, l1_rdata_o;
   logic        data_sram_req_o;
   logic [3:0]  data_sram_we_o;
   logic [31:0] data_sram_addr_o, data_sram_wdata_o;
   logic        data_sram_addr_ok_i, data_sram_data_ok_i;
   logic [31:0] data_sram_rdata_i;
   logic        busy_o, err_o;

   always #5 clk = ~clk;

   dcache_port_arbiter #(.OSTD_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .excep_flush_i(excep_flush_i),
      .l0_req_i(l0_req_i), .l0_we_i(l0_we_i), .l0_addr_i(l0_addr_i), .l0_wdata_i(l0_wdata_i),
      .l0_addr_ok_o(l0_addr_ok_o), .l0_data_ok_o(l0_data_ok_o), .l0_rdata_o(l0_rdata_o),
      .l1_req_i(l1_req_i), .l1_we_i(l1_we_i), .l1_addr_i(l1_addr_i), .l1_wdata_i(l1_wdata_i),
      .l1_addr_ok_o(l1_addr_ok_o), .l1_data_ok_o(l1_data_ok_o), .l1_rdata_o(l1_rdata_o),
      .data_sram_req_o(data_sram_req_o), .data_sram_we_o(data_sram_we_o),
      .data_sram_addr_o(data_sram_addr_o), .data_sram_wdata_o(data_sram_wdata_o),
      .data_sram_addr_ok_i(data_sram_addr_ok_i), .data_sram_data_ok_i(data_sram_data_ok_i),
      .data_sram_rdata_i(data_sram_rdata_i), .busy_o(busy_o), .err_o(err_o)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: lock = lane holding a stalled grant (-1 none); queues = accepted, unanswered
   int lock = -1;
   bit q_own[$];
   bit q_dis[$];
   bit acc0, acc1, flushed;

   task automatic model_reset();
      lock = -1;
      q_own.delete();
      q_dis.delete();
      acc0 = 0; acc1 = 0; flushed = 0;
   endtask

   task automatic model_step();
      int  own;
      bit  e_req, e_ao0, e_ao1, e_do0, e_do1, e_err, e_busy, h_own, h_dis;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_we;
      own    = (lock >= 0) ? lock : (l0_req_i ? 0 : (l1_req_i ? 1 : -1));
      e_req  = (own >= 0) && (q_own.size() < DEPTH) && !excep_flush_i;
      e_ao0  = e_req && data_sram_addr_ok_i && own == 0;
      e_ao1  = e_req && data_sram_addr_ok_i && own == 1;
      e_busy = (q_own.size() != 0) || (lock >= 0);
      e_err  = data_sram_data_ok_i && q_own.size() == 0;
      e_do0  = 0;
      e_do1  = 0;
      if (data_sram_data_ok_i && q_own.size() > 0) begin
         h_own = q_own.pop_front();
         h_dis = q_dis.pop_front();
         e_do0 = !h_dis && !h_own;
         e_do1 = !h_dis && h_own;
      end
      e_addr  = !e_req ? 32'h0 : (own == 0 ? l0_addr_i  : l1_addr_i);
      e_wdata = !e_req ? 32'h0 : (own == 0 ? l0_wdata_i : l1_wdata_i);
      e_we    = !e_req ? 4'h0  : (own == 0 ? l0_we_i    : l1_we_i);
      chk("ctl {req,aok0,aok1,dok0,dok1,busy,err}",
          32'({data_sram_req_o, l0_addr_ok_o, l1_addr_ok_o, l0_data_ok_o, l1_data_ok_o, busy_o, err_o}),
          32'({e_req, e_ao0, e_ao1, e_do0, e_do1, e_busy, e_err}));
      chk("addr", data_sram_addr_o, e_addr);
      chk("wdata", data_sram_wdata_o, e_wdata);
      chk("we", 32'(data_sram_we_o), 32'(e_we));
      if (e_do0) chk("l0_rdata", l0_rdata_o, data_sram_rdata_i);
      if (e_do1) chk("l1_rdata", l1_rdata_o, data_sram_rdata_i);
      if (excep_flush_i) foreach (q_dis[i]) q_dis[i] = 1'b1;
      if (e_ao0 || e_ao1) begin
         q_own.push_back(own == 1);
         q_dis.push_back(1'b0);
      end
      if (excep_flush_i || e_ao0 || e_ao1) lock = -1;
      else if (e_req)                      lock = own;
      acc0 = e_ao0; acc1 = e_ao1; flushed = excep_flush_i;
   endtask

   task automatic idle_inputs();
      excep_flush_i = 0; l0_req_i = 0; l1_req_i = 0;
      l0_we_i = 0; l1_we_i = 0; l0_addr_i = 0; l1_addr_i = 0; l0_wdata_i = 0; l1_wdata_i = 0;
      data_sram_addr_ok_i = 0; data_sram_data_ok_i = 0; data_sram_rdata_i = 0;
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      l0_req_i = 1;
      #2;
      chk("reset ctl", 32'({data_sram_req_o, l0_addr_ok_o, l1_addr_ok_o, l0_data_ok_o, l1_data_ok_o, busy_o, err_o}), 32'h0);
      chk("reset addr", data_sram_addr_o, 32'h0);
      l0_req_i = 0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1;
      model_reset();

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk); #1;
         if (acc0 || flushed) l0_req_i = 0;
         if (acc1 || flushed) l1_req_i = 0;
         if (!l0_req_i && $urandom_range(0, 2) != 0) begin
            l0_req_i   = 1;
            l0_addr_i  = $urandom & 32'hffff_fffc;
            l0_we_i    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            l0_wdata_i = $urandom;
         end
         if (!l1_req_i && $urandom_range(0, 2) != 0) begin
            l1_req_i   = 1;
            l1_addr_i  = $urandom & 32'hffff_fffc;
            l1_we_i    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            l1_wdata_i = $urandom;
         end
         data_sram_addr_ok_i = $urandom_range(0, 9) < 6;
         data_sram_data_ok_i = $urandom_range(0, 9) < 4;
         data_sram_rdata_i   = $urandom;
         excep_flush_i       = $urandom_range(0, 29) == 0;
         @(negedge clk);
         model_step();
      end

      // Reset mid-traffic, then a late response must flag err_o
      @(posedge clk); #1;
      idle_inputs();
      rst_n = 0;
      #1;
      chk("mid reset busy", 32'(busy_o), 32'h0);
      #1;
      rst_n = 1;
      model_reset();
      data_sram_data_ok_i = 1;
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
      data_sram_data_ok_i = 0;
      @(negedge clk);
      model_step();

      // Lock to lane 0, then reset: port request must drop immediately
      @(posedge clk); #1;
      l0_req_i = 1; l0_addr_i = 32'h0000_1000;
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
      l1_req_i = 1; l1_addr_i = 32'h0000_1004;
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("reset in LOCK0 req", 32'(data_sram_req_o), 32'h0);
      chk("reset in LOCK0 busy", 32'(busy_o), 32'h0);
      idle_inputs();
      #1;
      rst_n = 1;
      model_reset();
      @(negedge clk);
      model_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
